// File: rtl/ldpc_ber_monitor_if.sv
// rtl/ldpc_ber_monitor_if.sv - frame handshake bundle between decoder harness and BER monitor
interface ldpc_ber_monitor_if #(
    parameter int NN = 208
);
    logic          frame_valid;
    logic          frame_ready;
    logic [NN-1:0] ref_word;
    logic [NN-1:0] dec_word;
    logic          dec_pass;

    modport master (
        output frame_valid, ref_word, dec_word, dec_pass,
        input  frame_ready
    );

    modport slave (
        input  frame_valid, ref_word, dec_word, dec_pass,
        output frame_ready
    );
endinterface

// File: rtl/ldpc_ber_monitor.sv
// rtl/ldpc_ber_monitor.sv - LDPC bit/frame error statistics monitor with chunked popcount
// Defining LDPC_BER_MAXERR_EN enables worst-frame tracking on max_bit_err.
module ldpc_ber_monitor #(
    parameter int NN    = 208,
    parameter int CHUNK = 16,
    parameter int CNT_W = 32
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    ldpc_ber_monitor_if.slave        frm,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic [CNT_W-1:0]         bit_err_cnt,
    output logic [CNT_W-1:0]         frame_err_cnt,
    output logic [CNT_W-1:0]         undetected_cnt,
    output logic [$clog2(NN+1)-1:0]  last_bit_err,
    output logic [$clog2(NN+1)-1:0]  max_bit_err,
    output logic                     busy,
    output logic                     done,
    output logic                     sat
);
    localparam int NCHUNK = (NN + CHUNK - 1) / CHUNK;
    localparam int EW     = $clog2(NN + 1);
    localparam int IW     = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {IDLE, COUNT, UPDATE} state_t;

    state_t         state, state_nxt;
    logic [NN-1:0]  diff;
    logic           pass_q;
    logic [EW-1:0]  acc;
    logic [EW-1:0]  chunk_pop;
    logic [IW-1:0]  idx;
    logic           err;
    logic [CNT_W:0] fc_sum, be_sum, fe_sum, ud_sum;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        frm.frame_ready = 1'b0;
        busy            = 1'b1;
        case (state)
            IDLE: begin
                frm.frame_ready = 1'b1;
                busy            = 1'b0;
                if (frm.frame_valid) state_nxt = COUNT;
            end
            COUNT:   if (idx == IW'(NCHUNK - 1)) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shifting with zero fill makes the final partial chunk count only real bits.
    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) chunk_pop = chunk_pop + EW'(diff[i]);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            diff   <= '0;
            pass_q <= 1'b0;
            acc    <= '0;
            idx    <= '0;
        end else if (state == IDLE) begin
            if (frm.frame_valid) begin
                diff   <= frm.ref_word ^ frm.dec_word;
                pass_q <= frm.dec_pass;
                acc    <= '0;
                idx    <= '0;
            end
        end else if (state == COUNT) begin
            acc  <= acc + chunk_pop;
            diff <= diff >> CHUNK;
            idx  <= idx + IW'(1);
        end
    end

    assign err = (acc != '0);

    // One extra bit on each sum exposes the overflow that drives saturation.
    always_comb begin
        fc_sum = {1'b0, frame_cnt}      + (CNT_W+1)'(1);
        be_sum = {1'b0, bit_err_cnt}    + (CNT_W+1)'(acc);
        fe_sum = {1'b0, frame_err_cnt}  + (CNT_W+1)'(err);
        ud_sum = {1'b0, undetected_cnt} + (CNT_W+1)'(err & pass_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            frame_cnt      <= '0;
            bit_err_cnt    <= '0;
            frame_err_cnt  <= '0;
            undetected_cnt <= '0;
            last_bit_err   <= '0;
            sat            <= 1'b0;
        end else if (clr_stats) begin
            frame_cnt      <= '0;
            bit_err_cnt    <= '0;
            frame_err_cnt  <= '0;
            undetected_cnt <= '0;
            last_bit_err   <= '0;
            sat            <= 1'b0;
        end else if (state == UPDATE) begin
            frame_cnt      <= fc_sum[CNT_W] ? '1 : fc_sum[CNT_W-1:0];
            bit_err_cnt    <= be_sum[CNT_W] ? '1 : be_sum[CNT_W-1:0];
            frame_err_cnt  <= fe_sum[CNT_W] ? '1 : fe_sum[CNT_W-1:0];
            undetected_cnt <= ud_sum[CNT_W] ? '1 : ud_sum[CNT_W-1:0];
            last_bit_err   <= acc;
            sat            <= sat | fc_sum[CNT_W] | be_sum[CNT_W] | fe_sum[CNT_W] | ud_sum[CNT_W];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) done <= 1'b0;
        else          done <= (state == UPDATE);
    end

`ifdef LDPC_BER_MAXERR_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                             max_bit_err <= '0;
        else if (clr_stats)                       max_bit_err <= '0;
        else if (state == UPDATE && acc > max_bit_err) max_bit_err <= acc;
    end
`else
    assign max_bit_err = '0;
`endif

endmodule
